fetch_sequencer: RTL and testbench

- Instruction-fetch controller that drives the program memory's byte `Address` input and captures its combinational `Instruction` output.
- Owns the PC, buffers fetched words in a 2-entry prefetch FIFO, and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage and flags out-of-range or misaligned fetches.
- Sits between the program memory and the IF/ID pipeline register.

---
 rtl/mips_fetch_pkg.sv | 34 +++
 rtl/fetch_sequencer_if.sv | 27 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds the fetch constants, the FSM state encoding, the prefetch entry
// payload {instr, pc} and the program-memory range check.
package mips_fetch_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned MEMORY_DEPTH = 128;
  localparam int unsigned FIFO_DEPTH   = 2;
  localparam logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // One prefetch slot: fetched word plus the byte address it came from.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Word-aligned and inside [base, base + 4*depth); uses an offset compare
  // so the upper bound never has to be formed and cannot overflow.
  function automatic logic in_range(input logic [DATA_WIDTH-1:0] addr,
                                    input logic [DATA_WIDTH-1:0] base,
                                    input int unsigned           depth);
    logic [DATA_WIDTH-1:0] span;
    span = DATA_WIDTH'(depth) << 2;
    return (addr[1:0] == 2'b00) && (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-unit bus: program-memory address/data, redirect request from
// execute, and the valid/ready instruction handoff to decode.
//   master : the fetch sequencer
//   slave  : program memory + execute + decode side
interface fetch_sequencer_if;
  import mips_fetch_pkg::*;

  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_instruction;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_out;
  logic [DATA_WIDTH-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_instruction, inst_ready,
    output mem_address, inst_valid, inst_out, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_instruction, inst_ready,
    input  mem_address, inst_valid, inst_out, inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer, head always in slot 0.
// Ports: clk, reset (async active-low), push/pop/flush (synchronous),
//        din (entry to append), full, empty, head (slot 0 contents).
// Slot 0 is left untouched when the buffer empties or is flushed, so the
// head keeps showing the last instruction presented to decode.
module fetch_fifo
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t              ent_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     vld_q;

  // Shift-down storage; caller never pushes into a full FIFO without a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '{default: '0};
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (vld_q[1]) begin
            ent_q[0] <= ent_q[1];
            ent_q[1] <= din;
          end else begin
            ent_q[0] <= din;
          end
        end
        2'b10: begin
          if (!vld_q[0]) begin
            ent_q[0] <= din;
            vld_q[0] <= 1'b1;
          end else begin
            ent_q[1] <= din;
            vld_q[1] <= 1'b1;
          end
        end
        2'b01: begin
          if (vld_q[1]) ent_q[0] <= ent_q[1];
          vld_q <= {1'b0, vld_q[1]};
        end
        default: ;
      endcase
    end
  end

  assign full  = vld_q[1];
  assign empty = !vld_q[0];
  assign head  = ent_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives program-memory byte
// address, buffers fetched words in a 2-entry prefetch FIFO and hands
// them to decode over valid/ready. Redirects from execute flush the FIFO;
// out-of-range or misaligned fetch addresses raise a sticky fault.
// Ports: clk, reset (async active-low), enable (run request),
//        bus (fetch_sequencer_if.master: memory, redirect, decode handoff),
//        fault / fault_pc (sticky fault flag and offending address).
module fetch_sequencer #(
  parameter int unsigned                             MEMORY_DEPTH = mips_fetch_pkg::MEMORY_DEPTH,
  parameter logic [mips_fetch_pkg::DATA_WIDTH-1:0]   TEXT_BASE    = mips_fetch_pkg::TEXT_BASE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  fetch_sequencer_if.master                    bus,
  output logic                                 fault,
  output logic [mips_fetch_pkg::DATA_WIDTH-1:0] fault_pc
);
  import mips_fetch_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_d;
  logic [DATA_WIDTH-1:0] fault_pc_d;
  logic                  push_c, pop_c, flush_c;
  logic                  fifo_full, fifo_empty;
  fetch_entry_t          fifo_head, fifo_din;

  // Next-state / control; a redirect overrides everything else this cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault;
    fault_pc_d = fault_pc;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    flush_c    = 1'b0;

    if (bus.redirect_valid) begin
      flush_c = 1'b1;
      if (in_range(bus.redirect_pc, TEXT_BASE, MEMORY_DEPTH)) begin
        pc_d    = bus.redirect_pc;
        fault_d = 1'b0;
        state_d = enable ? FETCH : IDLE;
      end else begin
        state_d    = FAULT;
        fault_d    = 1'b1;
        fault_pc_d = bus.redirect_pc;
      end
    end else begin
      pop_c = !fifo_empty && bus.inst_ready;
      case (state_q)
        IDLE: begin
          if (enable) state_d = FETCH;
        end
        FETCH: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (!in_range(pc_q, TEXT_BASE, MEMORY_DEPTH)) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end else if (fifo_full && !pop_c) begin
            state_d = FULL;
          end else begin
            push_c = 1'b1;
            pc_d   = pc_q + DATA_WIDTH'(4);
          end
        end
        FULL: begin
          if (pop_c) state_d = FETCH;
        end
        FAULT: ;
        default: ;
      endcase
    end
  end

  // State, PC and fault registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= TEXT_BASE;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fault    <= fault_d;
      fault_pc <= fault_pc_d;
    end
  end

  // Memory returns the word combinationally, so it is captured with the
  // current PC in the same cycle.
  assign fifo_din = '{instr: bus.mem_instruction, pc: pc_q};

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign bus.mem_address = pc_q;
  assign bus.inst_valid  = !fifo_empty;
  assign bus.inst_out    = fifo_head.instr;
  assign bus.inst_pc     = fifo_head.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations,
// then randomized enable/ready/redirect/reset traffic, all compared every
// cycle against a queue-based behavioural model.
module tb_fetch_sequencer;
  import mips_fetch_pkg::*;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int unsigned DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fault;
  logic [31:0] fault_pc;

  fetch_sequencer_if bus();

  fetch_sequencer #(.MEMORY_DEPTH(DEPTH), .TEXT_BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .fault    (fault),
    .fault_pc (fault_pc)
  );

  always #5 clk = ~clk;

  // Program memory
  logic [31:0] mem [DEPTH];
  logic [6:0]  mem_idx;

  function automatic bit in_text(input logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = 64'(a);
    lo = 64'(BASE);
    hi = lo + 64'(4 * DEPTH);
    return (a[1:0] == 2'b00) && (x >= lo) && (x < hi);
  endfunction

  assign mem_idx             = 7'((bus.mem_address - BASE) >> 2);
  assign bus.mem_instruction = in_text(bus.mem_address) ? mem[mem_idx]
                                                        : (bus.mem_address ^ 32'hA5A5_5A5A);

  // Counters
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model
  typedef enum {M_IDLE, M_FETCH, M_FULL, M_FAULT} mode_e;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  mode_e       m_mode     = M_IDLE;
  logic [31:0] m_pc       = BASE;
  logic        m_fault    = 1'b0;
  logic [31:0] m_fault_pc = '0;
  logic [31:0] m_out      = '0;
  logic [31:0] m_out_pc   = '0;
  bit          m_pop;
  bit          m_push;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      m_mode     = M_IDLE;
      m_pc       = BASE;
      m_fault    = 1'b0;
      m_fault_pc = '0;
      m_out      = '0;
      m_out_pc   = '0;
    end else begin
      m_pop  = 1'b0;
      m_push = 1'b0;
      if (bus.redirect_valid) begin
        mq.delete();
        if (in_text(bus.redirect_pc)) begin
          m_pc    = bus.redirect_pc;
          m_fault = 1'b0;
          m_mode  = enable ? M_FETCH : M_IDLE;
        end else begin
          m_mode     = M_FAULT;
          m_fault    = 1'b1;
          m_fault_pc = bus.redirect_pc;
        end
      end else begin
        m_pop = (mq.size() > 0) && bus.inst_ready;
        case (m_mode)
          M_IDLE:  if (enable) m_mode = M_FETCH;
          M_FETCH: begin
            if (!enable) m_mode = M_IDLE;
            else if (!in_text(m_pc)) begin
              m_mode     = M_FAULT;
              m_fault    = 1'b1;
              m_fault_pc = m_pc;
            end else if (mq.size() == 2 && !m_pop) m_mode = M_FULL;
            else m_push = 1'b1;
          end
          M_FULL:  if (m_pop) m_mode = M_FETCH;
          default: ;
        endcase
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{instr: mem[7'((m_pc - BASE) >> 2)], pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
      if (mq.size() > 0) begin
        m_out    = mq[0].instr;
        m_out_pc = mq[0].pc;
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("mdl_inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
    chk("mdl_inst_out",   bus.inst_out,        m_out);
    chk("mdl_inst_pc",    bus.inst_pc,         m_out_pc);
    chk("mdl_mem_address", bus.mem_address,    m_pc);
    chk("mdl_fault",      32'(fault),          32'(m_fault));
    chk("mdl_fault_pc",   fault_pc,            m_fault_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  logic [31:0] rp;
  int unsigned sel;

  initial begin
    reset              = 1'b1;
    enable             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    #2 reset = 1'b0;
    tick();
    tick();

    // Reset release, streaming with ready high
    reset  = 1'b1;
    enable = 1'b1;
    tick();
    chk("boot_valid_c1", 32'(bus.inst_valid), 32'd0);
    chk("boot_addr_c1",  bus.mem_address, 32'h0040_0000);
    tick();
    chk("boot_valid_c2", 32'(bus.inst_valid), 32'd1);
    chk("boot_pc0",  bus.inst_pc,  32'h0040_0000);
    chk("boot_out0", bus.inst_out, 32'h2008_0001);
    tick();
    chk("boot_pc1",  bus.inst_pc,  32'h0040_0004);
    chk("boot_out1", bus.inst_out, 32'h2009_0002);
    tick();
    chk("boot_pc2",  bus.inst_pc,  32'h0040_0008);
    chk("boot_out2", bus.inst_out, 32'h0109_5020);

    // Backpressure from reset: two pushes then frozen
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    bus.inst_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("bp_addr_c3", bus.mem_address, 32'h0040_0008);
    tick();
    tick();
    chk("bp_addr_c5", bus.mem_address, 32'h0040_0008);
    chk("bp_valid",   32'(bus.inst_valid), 32'd1);
    chk("bp_head",    bus.inst_pc, 32'h0040_0000);
    bus.inst_ready = 1'b1;
    tick();
    chk("drain_pc1", bus.inst_pc, 32'h0040_0004);
    tick();
    chk("drain_pc2",  bus.inst_pc,  32'h0040_0008);
    chk("drain_out2", bus.inst_out, 32'h0109_5020);
    tick();
    chk("drain_pc3", bus.inst_pc, 32'h0040_000C);

    // Redirect while full
    bus.inst_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("full_addr", bus.mem_address, 32'h0040_0014);
    chk("full_head", bus.inst_pc, 32'h0040_000C);
    bus.inst_ready = 1'b1;
    redirect(32'h0040_0040);
    chk("redir_valid_n1", 32'(bus.inst_valid), 32'd0);
    chk("redir_addr_n1",  bus.mem_address, 32'h0040_0040);
    tick();
    chk("redir_valid_n2", 32'(bus.inst_valid), 32'd1);
    chk("redir_pc_n2",    bus.inst_pc, 32'h0040_0040);
    chk("redir_out_n2",   bus.inst_out, mem[16]);

    // Faulting redirects, then recovery
    redirect(32'h0040_0202);
    chk("misal_fault",    32'(fault), 32'd1);
    chk("misal_fault_pc", fault_pc, 32'h0040_0202);
    tick();
    redirect(32'h0040_0200);
    chk("end_fault",    32'(fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'h0040_0200);
    tick();
    chk("fault_sticky", 32'(fault), 32'd1);
    redirect(32'h0040_0010);
    chk("recover_fault", 32'(fault), 32'd0);
    chk("recover_addr",  bus.mem_address, 32'h0040_0010);
    tick();
    chk("recover_pc", bus.inst_pc, 32'h0040_0010);

    // Sequential fetch off the end of memory
    bus.inst_ready = 1'b0;
    redirect(32'h0040_01F8);
    tick();
    tick();
    tick();
    chk("seq_fault",    32'(fault), 32'd1);
    chk("seq_fault_pc", fault_pc, 32'h0040_0200);
    chk("seq_addr",     bus.mem_address, 32'h0040_0200);
    chk("seq_head",     bus.inst_pc, 32'h0040_01F8);
    bus.inst_ready = 1'b1;
    tick();
    chk("seq_drain", bus.inst_pc, 32'h0040_01FC);
    tick();
    chk("seq_empty", 32'(bus.inst_valid), 32'd0);
    chk("seq_fault_hold", 32'(fault), 32'd1);

    // Reset in the middle of a redirect cycle
    redirect(32'h0040_0010);
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0080;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid",    32'(bus.inst_valid), 32'd0);
    chk("rst_out",      bus.inst_out, 32'd0);
    chk("rst_pc",       bus.inst_pc, 32'd0);
    chk("rst_fault",    32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_addr",     bus.mem_address, 32'h0040_0000);
    bus.redirect_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("restart_addr",  bus.mem_address, 32'h0040_0000);
    chk("restart_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    chk("restart_pc",  bus.inst_pc, 32'h0040_0000);
    chk("restart_out", bus.inst_out, 32'h2008_0001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      enable             = ($urandom_range(0, 15) != 0);
      bus.inst_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)       rp = BASE + 32'(4 * $urandom_range(0, 127));
      else if (sel == 6) rp = BASE + 32'(4 * $urandom_range(0, 127)) + 32'($urandom_range(1, 3));
      else if (sel == 7) rp = BASE + 32'(4 * $urandom_range(124, 127));
      else if (sel == 8) rp = BASE + 32'(4 * $urandom_range(128, 200));
      else               rp = BASE - 32'(4 * $urandom_range(1, 16));
      bus.redirect_pc = rp;
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
